// File: rtl/kodd_vec_pkg.sv
// Shared types for the vector memory sequencer: lane indexing, FSM states and lane vectors.
package kodd_vec_pkg;

    localparam int LANES  = 4;
    localparam int DW     = 32;
    localparam int LANE_W = $clog2(LANES);

    typedef logic [LANE_W-1:0] lane_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LAST,
        DONE
    } vms_state_t;

    typedef logic [LANES-1:0][DW-1:0] lane_vec_t;

endpackage

// File: rtl/vms_next_lane.sv
// Finds the next enabled lane above (or, with incl, at) the current index.
// The mask port exists only when VMS_LANE_MASK_EN is defined; otherwise lanes simply count up.
module vms_next_lane #(
    parameter int LANES = 4,
    parameter int LW    = $clog2(LANES)
) (
`ifdef VMS_LANE_MASK_EN
    input  logic [LANES-1:0] mask,
`endif
    input  logic [LW-1:0]    cur,
    input  logic             incl,
    output logic [LW-1:0]    nxt,
    output logic             none
);

`ifdef VMS_LANE_MASK_EN
    // Scan downwards so the lowest qualifying lane wins.
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
                nxt  = LW'(i);
                none = 1'b0;
            end
        end
    end
`else
    assign nxt  = incl ? cur : cur + 1'b1;
    assign none = !incl && (cur == LW'(LANES - 1));
`endif

endmodule

// File: rtl/vec_mem_sequencer.sv
// Serialises a multi-lane vector load/store onto a single-ported data RAM, one lane per cycle.
// Optional lane masking is compiled in with VMS_LANE_MASK_EN.
module vec_mem_sequencer #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vec_req_i,
    input  logic                vec_we_i,
    input  logic [LANES*AW-1:0] vec_addr_i,
    input  logic [LANES*DW-1:0] vec_wdata_i,
`ifdef VMS_LANE_MASK_EN
    input  logic [LANES-1:0]    vec_mask_i,
`endif
    output logic [LANES*DW-1:0] vec_rdata_o,
    output logic                vec_done_o,
    input  logic                sc_req_i,
    input  logic                sc_we_i,
    input  logic [AW-1:0]       sc_addr_i,
    input  logic [DW-1:0]       sc_wdata_i,
    output logic [DW-1:0]       sc_rdata_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [DW-1:0]       mem_wdata_o,
    input  logic [DW-1:0]       mem_rdata_i,
    output logic                stall_o,
    output logic                err_o
);
    import kodd_vec_pkg::*;

    localparam int LW = $clog2(LANES);

    vms_state_t          state, state_nxt;
    logic [LW-1:0]       cnt;
    logic                we_q;
    logic [LANES*AW-1:0] addr_q;
    logic [LANES*DW-1:0] wdata_q;
    logic [LANES*DW-1:0] rdata_q;
    logic                rd_pend;
    logic [LW-1:0]       rd_lane;
    logic                err_q;
    logic [LW-1:0]       first_lane, next_lane;
    logic                first_none, next_none;

`ifdef VMS_LANE_MASK_EN
    logic [LANES-1:0]    mask_q;

    vms_next_lane #(.LANES(LANES), .LW(LW)) u_first (
        .mask (vec_mask_i),
        .cur  ('0),
        .incl (1'b1),
        .nxt  (first_lane),
        .none (first_none)
    );

    vms_next_lane #(.LANES(LANES), .LW(LW)) u_next (
        .mask (mask_q),
        .cur  (cnt),
        .incl (1'b0),
        .nxt  (next_lane),
        .none (next_none)
    );
`else
    vms_next_lane #(.LANES(LANES), .LW(LW)) u_first (
        .cur  ('0),
        .incl (1'b1),
        .nxt  (first_lane),
        .none (first_none)
    );

    vms_next_lane #(.LANES(LANES), .LW(LW)) u_next (
        .cur  (cnt),
        .incl (1'b0),
        .nxt  (next_lane),
        .none (next_none)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vec_req_i) state_nxt = first_none ? DONE : ISSUE;
            ISSUE:   if (next_none) state_nxt = we_q ? DONE : LAST;
            LAST:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Scalar traffic owns the RAM only while idle and no vector is being accepted.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = addr_q[int'(cnt)*AW +: AW];
        mem_wdata_o = wdata_q[int'(cnt)*DW +: DW];
        stall_o     = 1'b0;
        vec_done_o  = 1'b0;
        case (state)
            IDLE: begin
                if (vec_req_i) begin
                    stall_o = 1'b1;
                end else begin
                    mem_en_o    = sc_req_i;
                    mem_we_o    = sc_req_i & sc_we_i;
                    mem_addr_o  = sc_addr_i;
                    mem_wdata_o = sc_wdata_i;
                end
            end
            ISSUE: begin
                mem_en_o = 1'b1;
                mem_we_o = we_q;
                stall_o  = 1'b1;
            end
            LAST:    stall_o = 1'b1;
            DONE:    vec_done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_pend <= 1'b0;
            rd_lane <= '0;
            err_q   <= 1'b0;
`ifdef VMS_LANE_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            rd_pend <= 1'b0;
            // RAM data arrives one cycle after the issue that requested it.
            if (rd_pend) begin
                rdata_q[int'(rd_lane)*DW +: DW] <= mem_rdata_i;
            end
            if (sc_req_i && ((state != IDLE) || vec_req_i)) begin
                err_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (vec_req_i) begin
                        we_q    <= vec_we_i;
                        addr_q  <= vec_addr_i;
                        wdata_q <= vec_wdata_i;
                        cnt     <= first_lane;
`ifdef VMS_LANE_MASK_EN
                        mask_q  <= vec_mask_i;
                        for (int k = 0; k < LANES; k++) begin
                            if (!vec_mask_i[k]) rdata_q[k*DW +: DW] <= '0;
                        end
`endif
                    end
                end
                ISSUE: begin
                    rd_pend <= !we_q;
                    rd_lane <= cnt;
                    cnt     <= next_none ? '0 : next_lane;
                end
                default: ;
            endcase
        end
    end

    assign vec_rdata_o = rdata_q;
    assign sc_rdata_o  = mem_rdata_i;
    assign err_o       = err_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: directed cases plus randomized vector/scalar traffic.
// Lane-mask cases are built in when VMS_LANE_MASK_EN is defined.
module tb_vec_mem_sequencer;
    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                vec_req, vec_we;
    logic [LANES*AW-1:0] vec_addr;
    logic [LANES*DW-1:0] vec_wdata;
`ifdef VMS_LANE_MASK_EN
    logic [LANES-1:0]    vec_mask;
`endif
    logic [LANES*DW-1:0] vec_rdata;
    logic                vec_done;
    logic                sc_req, sc_we;
    logic [AW-1:0]       sc_addr;
    logic [DW-1:0]       sc_wdata, sc_rdata;
    logic                mem_en, mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata = '0;
    logic                stall, err;

    int n_checks = 0;
    int n_errors = 0;

    // RAM the DUT drives, and the bench's own view of what it should contain.
    logic [DW-1:0] ram     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    logic [31:0]   exp_q[$];

    always #5 clk = ~clk;

    vec_mem_sequencer #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .vec_req_i   (vec_req),
        .vec_we_i    (vec_we),
        .vec_addr_i  (vec_addr),
        .vec_wdata_i (vec_wdata),
`ifdef VMS_LANE_MASK_EN
        .vec_mask_i  (vec_mask),
`endif
        .vec_rdata_o (vec_rdata),
        .vec_done_o  (vec_done),
        .sc_req_i    (sc_req),
        .sc_we_i     (sc_we),
        .sc_addr_i   (sc_addr),
        .sc_wdata_i  (sc_wdata),
        .sc_rdata_o  (sc_rdata),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .stall_o     (stall),
        .err_o       (err)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[11:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Starts and ends just after a rising edge. The whole op is predicted from the lane
    // list: n enabled lanes issue in cycles 1..n, done follows after n+1 (store) or n+2 (load).
    task automatic run_vec(input logic we, input logic [LANES*AW-1:0] a_v,
                           input logic [LANES*DW-1:0] d_v, input logic [LANES-1:0] mask_in,
                           input logic sc_also);
        logic [LANES-1:0] m;
        logic [31:0]      exp_rd [LANES];
        logic [31:0]      lane, a;
        int               n, exp_done, done_cyc, stall_n, issued;
        m = mask_in;
`ifndef VMS_LANE_MASK_EN
        m = '1;
`endif
        exp_q.delete();
        for (int k = 0; k < LANES; k++) begin
            a = a_v[k*AW +: AW];
            exp_rd[k] = m[k] ? ref_mem[a[11:2]] : 32'h0;
            if (m[k]) exp_q.push_back(k);
        end
        n        = exp_q.size();
        exp_done = (n == 0) ? 1 : (we ? n + 1 : n + 2);
        done_cyc = -1;
        stall_n  = 0;
        issued   = 0;
        vec_req   = 1'b1;
        vec_we    = we;
        vec_addr  = a_v;
        vec_wdata = d_v;
`ifdef VMS_LANE_MASK_EN
        vec_mask  = m;
`endif
        if (sc_also) begin
            sc_req   = 1'b1;
            sc_we    = 1'b1;
            sc_addr  = 32'hFFC;
            sc_wdata = 32'hDEADBEEF;
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (mem_en) begin
                check("issue_cycle", 32'(c), 32'(issued + 1));
                if (exp_q.size() > 0) begin
                    lane = exp_q.pop_front();
                    check("issue_addr", mem_addr, a_v[lane*AW +: AW]);
                    check("issue_we", 32'(mem_we), 32'(we));
                    if (we) check("issue_wdata", mem_wdata, d_v[lane*DW +: DW]);
                end else begin
                    check("extra_issue", mem_addr, 32'hFFFF_FFFF);
                end
                issued++;
            end
            if (vec_done) begin
                done_cyc = c;
                if (!we) begin
                    for (int k = 0; k < LANES; k++) begin
                        check($sformatf("rdata_lane%0d", k), vec_rdata[k*DW +: DW], exp_rd[k]);
                    end
                end
                break;
            end
            @(posedge clk);
            #1;
            sc_req = 1'b0;
            sc_we  = 1'b0;
        end
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("stall_cycles", 32'(stall_n), 32'(exp_done));
        check("lanes_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        vec_req = 1'b0;
        sc_req  = 1'b0;
        sc_we   = 1'b0;
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                a = a_v[k*AW +: AW];
                if (m[k]) ref_mem[a[11:2]] = d_v[k*DW +: DW];
            end
        end
    endtask

    task automatic sc_read(input logic [31:0] addr);
        sc_req  = 1'b1;
        sc_we   = 1'b0;
        sc_addr = addr;
        @(negedge clk);
        check("sc_rd_en", 32'(mem_en), 32'd1);
        check("sc_rd_addr", mem_addr, addr);
        check("sc_rd_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        sc_req = 1'b0;
        @(negedge clk);
        check("sc_rdata", sc_rdata, ref_mem[addr[11:2]]);
        @(posedge clk);
        #1;
    endtask

    task automatic sc_write(input logic [31:0] addr, input logic [31:0] data);
        sc_req   = 1'b1;
        sc_we    = 1'b1;
        sc_addr  = addr;
        sc_wdata = data;
        @(negedge clk);
        check("sc_wr_en", 32'(mem_en & mem_we), 32'd1);
        check("sc_wr_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        sc_req = 1'b0;
        sc_we  = 1'b0;
        ref_mem[addr[11:2]] = data;
    endtask

    function automatic logic [LANES*AW-1:0] rand_addrs();
        logic [LANES*AW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*AW +: AW] = 32'($urandom_range(0, 1023)) << 2;
        return v;
    endfunction

    function automatic logic [LANES*DW-1:0] rand_data();
        logic [LANES*DW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*DW +: DW] = $urandom() | 32'h1;
        return v;
    endfunction

    initial begin
        logic [LANES*AW-1:0] a_v;
        logic [LANES*DW-1:0] d_v;
        logic [31:0]         a;

        for (int i = 0; i < 1024; i++) begin
            ram[i]     = $urandom() | 32'h1;
            ref_mem[i] = ram[i];
        end
        for (int k = 0; k < 4; k++) begin
            ram[32'h40 + k]     = 32'hA0 + k;
            ref_mem[32'h40 + k] = 32'hA0 + k;
        end

        // Clock/reset
        reset = 1'b0;
        vec_req = 1'b0; vec_we = 1'b0; vec_addr = '0; vec_wdata = '0;
`ifdef VMS_LANE_MASK_EN
        vec_mask = '1;
`endif
        sc_req = 1'b0; sc_we = 1'b0; sc_addr = '0; sc_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", 32'(vec_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        for (int k = 0; k < LANES; k++) check("rst_rdata", vec_rdata[k*DW +: DW], 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed load of 0x100..0x10C
        for (int k = 0; k < LANES; k++) a_v[k*AW +: AW] = 32'h100 + 32'(4 * k);
        run_vec(1'b0, a_v, '0, 4'hF, 1'b0);

        // Directed store 0x11..0x44 to 0x200.., then read back through the scalar port
        for (int k = 0; k < LANES; k++) begin
            a_v[k*AW +: AW] = 32'h200 + 32'(4 * k);
            d_v[k*DW +: DW] = 32'h11 * (k + 1);
        end
        run_vec(1'b1, a_v, d_v, 4'hF, 1'b0);
        for (int k = 0; k < LANES; k++) sc_read(32'h200 + 32'(4 * k));

        sc_read(32'h300);
        sc_write(32'h304, 32'hCAFE_0001);
        sc_read(32'h304);

        // Back-to-back vector ops
        run_vec(1'b0, rand_addrs(), '0, 4'hF, 1'b0);
        run_vec(1'b1, rand_addrs(), rand_data(), 4'hF, 1'b0);

`ifdef VMS_LANE_MASK_EN
        for (int k = 0; k < LANES; k++) a_v[k*AW +: AW] = 32'h100 + 32'(4 * k);
        run_vec(1'b0, a_v, '0, 4'b1010, 1'b0);
        run_vec(1'b0, a_v, '0, 4'b0000, 1'b0);
        run_vec(1'b1, rand_addrs(), rand_data(), 4'b0000, 1'b0);
`endif

        // Scalar colliding with vector accept: vector wins, scalar write dropped, error sticks
        check("err_before", 32'(err), 32'd0);
        run_vec(1'b0, rand_addrs(), '0, 4'hF, 1'b1);
        check("err_set", 32'(err), 32'd1);
        sc_read(32'hFFC);
        check("err_sticky", 32'(err), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 14; i++) begin
            a_v = rand_addrs();
            d_v = rand_data();
            run_vec(1'($urandom_range(0, 1)), a_v, d_v, 4'($urandom_range(0, 15)), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                a = a_v[$urandom_range(0, LANES - 1)*AW +: AW];
                sc_read(a);
            end
        end

        // Reset during the lane-2 issue of a full load
        a_v = rand_addrs();
        vec_req   = 1'b1;
        vec_we    = 1'b0;
        vec_addr  = a_v;
`ifdef VMS_LANE_MASK_EN
        vec_mask  = '1;
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        vec_req = 1'b0;
        @(negedge clk);
        check("mid_lane2_en", 32'(mem_en), 32'd1);
        check("mid_lane2_addr", mem_addr, a_v[2*AW +: AW]);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_done", 32'(vec_done), 32'd0);
            check("post_rst_en", 32'(mem_en), 32'd0);
            check("post_rst_stall", 32'(stall), 32'd0);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < LANES; k++) check("post_rst_rdata", vec_rdata[k*DW +: DW], 32'h0);
        check("post_rst_err", 32'(err), 32'd0);

        run_vec(1'b0, rand_addrs(), '0, 4'hF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
